// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire protocol: FSM states, phase
// durations in microseconds and the frame checksum.
package dht11_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHostLow,
        StRespDelay,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StEndLow
    } dht11_state_e;

    localparam int unsigned RESP_DELAY_US = 30;
    localparam int unsigned RESP_LOW_US   = 80;
    localparam int unsigned RESP_HIGH_US  = 80;
    localparam int unsigned BIT_LOW_US    = 50;
    localparam int unsigned BIT0_HIGH_US  = 27;
    localparam int unsigned BIT1_HIGH_US  = 70;
    localparam int unsigned END_LOW_US    = 50;

    localparam int unsigned FRAME_BITS = 40;

    // Low byte of the byte sum; bit 0 flipped when a corrupt frame is requested.
    function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d,
                                                  input logic fault);
        logic [7:0] sum;
        sum = a + b + c + d;
        return sum ^ {7'd0, fault};
    endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the shared data line; resets to 1 (idle line high).
module dht11_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects the host start pulse, answers with the presence
// pulse and shifts out a 40-bit humidity/temperature frame on an open-drain line.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLKS_PER_US  = 50,
    parameter int unsigned START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dado_in,
    output logic       dado_oe,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       fault_inject,
    input  logic       no_response,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned StartCycles = START_MIN_US * CLKS_PER_US;
    localparam int unsigned TimerW      = $clog2(StartCycles + 1);
    localparam logic [TimerW-1:0] StartThr = TimerW'(StartCycles);
    localparam logic [TimerW-1:0] TimerMax = '1;

    function automatic logic [TimerW-1:0] phase_load(input int unsigned us);
        return TimerW'(us * CLKS_PER_US - 1);
    endfunction

    dht11_state_e      state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [5:0]        bit_idx_q, bit_idx_d;
    logic [39:0]       frame_q, frame_d;
    logic              dado_oe_q, dado_oe_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              line;
    logic              phase_done;

    dht11_line_sync u_line_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (dado_in),
        .q_o    (line)
    );

    assign phase_done = (timer_q == '0);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!line) begin
                    timer_d = '0;
                    state_d = StHostLow;
                end
            end
            StHostLow: begin
                if (!line) begin
                    if (timer_q != TimerMax) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else if (timer_q >= StartThr && !no_response) begin
                    state_d   = StRespDelay;
                    timer_d   = phase_load(RESP_DELAY_US);
                    bit_idx_d = '0;
                    frame_d   = {humid_int, humid_dec, temp_int, temp_dec,
                                 dht11_checksum(humid_int, humid_dec, temp_int, temp_dec,
                                                fault_inject)};
                end else begin
                    state_d = StIdle;
                end
            end
            StRespDelay: begin
                if (phase_done) begin
                    state_d = StRespLow;
                    timer_d = phase_load(RESP_LOW_US);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRespLow: begin
                if (phase_done) begin
                    state_d = StRespHigh;
                    timer_d = phase_load(RESP_HIGH_US);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StRespHigh: begin
                if (phase_done) begin
                    state_d = StBitLow;
                    timer_d = phase_load(BIT_LOW_US);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StBitLow: begin
                // frame_q[39] is always the bit currently on the wire
                if (phase_done) begin
                    state_d = StBitHigh;
                    timer_d = frame_q[39] ? phase_load(BIT1_HIGH_US) : phase_load(BIT0_HIGH_US);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StBitHigh: begin
                if (phase_done) begin
                    frame_d = {frame_q[38:0], 1'b0};
                    if (bit_idx_q == 6'(FRAME_BITS - 1)) begin
                        state_d = StEndLow;
                        timer_d = phase_load(END_LOW_US);
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        state_d   = StBitLow;
                        timer_d   = phase_load(BIT_LOW_US);
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StEndLow: begin
                if (phase_done) begin
                    state_d      = StIdle;
                    timer_d      = '0;
                    frame_done_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        dado_oe_d = state_d inside {StRespLow, StBitLow, StEndLow};
        busy_d    = !(state_d inside {StIdle, StHostLow});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            dado_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            frame_q      <= frame_d;
            dado_oe_q    <= dado_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dado_oe    = dado_oe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
